// File: rtl/msx_bus_access_pkg.sv
// Shared types for the MSX cartridge-bus transaction bridge.
package msx_bus_access_pkg;
  typedef enum logic [2:0] {ST_IDLE, ST_REQ, ST_DRIVE, ST_END, ST_DRAIN} state_t;
  localparam logic [7:0] TIMEOUT_FILL = 8'hFF;
endpackage

// File: rtl/msx_wait_timer.sv
// Saturating cycle counter with synchronous clear; DONE once MAX is reached.
module msx_wait_timer #(
  parameter int MAX = 64
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_done
);
  localparam int W = $clog2(MAX + 1);
  localparam logic [W-1:0] LIM = W'(MAX);

  logic [W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                 r_cnt <= '0;
    else if (i_clr)               r_cnt <= '0;
    else if (i_en && r_cnt != LIM) r_cnt <= r_cnt + 1'b1;
  end

  assign o_done = (r_cnt == LIM);
endmodule

// File: rtl/msx_bus_access.sv
// Turns filtered MSX bus strobes into one REQ/ACK transaction each, returns
// read data onto the bus and holds the Z80 in WAIT while a read is pending.
module msx_bus_access
  import msx_bus_access_pkg::*;
#(
  parameter logic [7:0] IO_BASE     = 8'h00,
  parameter logic [7:0] IO_MASK     = 8'h00,
  parameter int         TIMEOUT     = 64,
  parameter bit         ENABLE_WAIT = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [15:0] i_addr,
  input  logic [7:0]  i_din,
  input  logic        i_sltsl_n,
  input  logic        i_merq_n,
  input  logic        i_iorq_n,
  input  logic        i_rd_n,
  input  logic        i_wr_n,
  input  logic        i_m1_n,
  input  logic        i_rfsh_n,
  output logic [7:0]  o_dout,
  output logic        o_busdir_n,
  output logic        o_wait_n,
  output logic        o_req,
  output logic        o_req_io,
  output logic        o_req_we,
  output logic [15:0] o_req_addr,
  output logic [7:0]  o_req_wdata,
  input  logic        i_ack,
  input  logic [7:0]  i_rdata,
  output logic        o_timeout_err
);
  state_t      r_state, w_next;
  logic        r_req, r_req_io, r_req_we, r_busdir_n, r_wait_n, r_tmo_err, r_orphan;
  logic [15:0] r_req_addr;
  logic [7:0]  r_req_wdata, r_dout;
  logic        w_strobe, w_mem, w_io, w_hit, w_ack, w_done, w_tmo;

  assign w_strobe = !i_rd_n || !i_wr_n;
  assign w_mem    = !i_sltsl_n && !i_merq_n && i_rfsh_n && w_strobe;
  // M1 low with IORQ is an interrupt acknowledge, never a port access
  assign w_io     = !i_iorq_n && i_m1_n && (IO_MASK != 8'h00) && w_strobe &&
                    ((i_addr[7:0] & IO_MASK) == (IO_BASE & IO_MASK));
  assign w_hit    = w_mem || w_io;
  assign w_ack    = i_ack && r_req;
  assign w_tmo    = (r_state == ST_REQ) && !r_req_we && !w_ack && w_done;

  msx_wait_timer #(.MAX(TIMEOUT)) u_timer (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_clr  (r_state == ST_IDLE),
    .i_en   ((r_state == ST_REQ) && !r_req_we),
    .o_done (w_done)
  );

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (w_hit) w_next = ST_REQ;
      ST_REQ: begin
        if (w_ack)      w_next = r_req_we ? ST_END : ST_DRIVE;
        else if (w_tmo) w_next = ST_DRIVE;
      end
      ST_DRIVE: if (i_rd_n) w_next = ST_END;
      ST_END:   if (i_rd_n && i_wr_n) w_next = (r_orphan && !w_ack) ? ST_DRAIN : ST_IDLE;
      ST_DRAIN: if (w_ack) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_req       <= 1'b0;
      r_req_io    <= 1'b0;
      r_req_we    <= 1'b0;
      r_req_addr  <= '0;
      r_req_wdata <= '0;
      r_dout      <= TIMEOUT_FILL;
      r_busdir_n  <= 1'b1;
      r_wait_n    <= 1'b1;
      r_tmo_err   <= 1'b0;
      r_orphan    <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_tmo_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_hit) begin
          r_req       <= 1'b1;
          r_req_io    <= !w_mem;
          r_req_we    <= !i_wr_n;
          r_req_addr  <= i_addr;
          r_req_wdata <= i_din;
          r_wait_n    <= !(ENABLE_WAIT && i_wr_n);
        end
        ST_REQ: begin
          if (w_ack) begin
            r_req <= 1'b0;
            if (!r_req_we) begin
              r_dout     <= i_rdata;
              r_busdir_n <= 1'b0;
              r_wait_n   <= 1'b1;
            end
          end else if (w_tmo) begin
            // release the Z80 with filler data; REQ stays up until the late ACK
            r_dout     <= TIMEOUT_FILL;
            r_busdir_n <= 1'b0;
            r_wait_n   <= 1'b1;
            r_tmo_err  <= 1'b1;
            r_orphan   <= 1'b1;
          end
        end
        ST_DRIVE: begin
          if (i_rd_n) r_busdir_n <= 1'b1;
          if (w_ack) begin
            r_req    <= 1'b0;
            r_orphan <= 1'b0;
          end
        end
        default: if (w_ack) begin
          r_req    <= 1'b0;
          r_orphan <= 1'b0;
        end
      endcase
    end
  end

  assign o_req         = r_req;
  assign o_req_io      = r_req_io;
  assign o_req_we      = r_req_we;
  assign o_req_addr    = r_req_addr;
  assign o_req_wdata   = r_req_wdata;
  assign o_dout        = r_dout;
  assign o_busdir_n    = r_busdir_n;
  assign o_wait_n      = r_wait_n || i_rd_n;
  assign o_timeout_err = r_tmo_err;
endmodule
